serial_input_regs: RTL

- Host-facing command decoder that fills the CPU's serial-input registers from UART bytes.
- Consumes bytes from uart_rx and parses fixed 5-byte write packets.
- Drives the six 15-bit inputs of IO_register_file: DSKY verb, DSKY noun, AXI G/RA/RB/ATX.
- Answers each packet with a one-byte ACK/NAK through uart_tx, forming the host-to-AGC direction of the serial link.

---
 rtl/serial_input_regs.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/serial_input_regs.sv
// serial_input_regs: decodes 5-byte UART write packets (SYNC, ID, HI, LO, CHK)
// into six 15-bit CPU input registers and answers each packet with ACK/NAK.
module serial_input_regs #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic [14:0] DSKY_VERB_data,
    output logic [14:0] DSKY_NOUN_data,
    output logic [14:0] AXI_G_data,
    output logic [14:0] AXI_RA_data,
    output logic [14:0] AXI_RB_data,
    output logic [14:0] AXI_ATX_data,
    output logic [5:0]  update_strobe,
    output logic [7:0]  err_count,
    output logic        resp_overrun
);

    localparam logic [2:0] S_SYNC = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_HI   = 3'd2;
    localparam logic [2:0] S_LO   = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;

    localparam int unsigned         IDLE_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0]   IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]        state_q, state_d;
    logic [7:0]        id_q, id_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        lo_q, lo_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [7:0]        err_q, err_d;
    logic [14:0]       regs_q [6];
    logic [14:0]       regs_d [6];
    logic [5:0]        strobe_q, strobe_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              pending_q, pending_d;
    logic              overrun_q, overrun_d;

    logic              queue_resp;
    logic [7:0]        queue_byte;
    logic              chk_match;
    logic              id_ok;
    logic              hi_ok;
    logic              accept;

    // A packet is good only if the checksum, register index and HI framing bit all agree.
    assign chk_match = ((id_q ^ hi_q ^ lo_q) == rx_data);
    assign id_ok     = (id_q <= 8'd5);
    assign hi_ok     = ~hi_q[7];
    assign accept    = chk_match & id_ok & hi_ok;

    // A pending response goes out on the first cycle the transmitter is free.
    assign tx_start  = pending_q & ~tx_busy;

    // Packet parser, idle timeout, register writes and error counting.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        idle_d     = idle_q;
        err_d      = err_q;
        regs_d     = regs_q;
        strobe_d   = 6'b000000;
        queue_resp = 1'b0;
        queue_byte = ACK_BYTE;
        if (rx_valid) begin
            idle_d = '0;
            case (state_q)
                S_SYNC: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = S_ID;
                    end
                end
                S_ID: begin
                    id_d    = rx_data;
                    state_d = S_HI;
                end
                S_HI: begin
                    hi_d    = rx_data;
                    state_d = S_LO;
                end
                S_LO: begin
                    lo_d    = rx_data;
                    state_d = S_CHK;
                end
                S_CHK: begin
                    state_d    = S_SYNC;
                    queue_resp = 1'b1;
                    if (accept) begin
                        queue_byte = ACK_BYTE;
                        for (int i = 0; i < 6; i++) begin
                            if (id_q == 8'(i)) begin
                                regs_d[i]   = {hi_q[6:0], lo_q};
                                strobe_d[i] = 1'b1;
                            end
                        end
                    end else begin
                        queue_byte = NAK_BYTE;
                        if (err_q != 8'hFF) begin
                            err_d = err_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_d = S_SYNC;
                end
            endcase
        end else if (state_q != S_SYNC) begin
            if (idle_q == IDLE_LAST) begin
                state_d = S_SYNC;
                idle_d  = '0;
                if (err_q != 8'hFF) begin
                    err_d = err_q + 8'd1;
                end
            end else begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end
    end

    // Single-entry response buffer; a queue that coincides with a send is not an overrun.
    always_comb begin
        tx_data_d = tx_data_q;
        pending_d = pending_q & ~tx_start;
        overrun_d = overrun_q;
        if (queue_resp) begin
            tx_data_d = queue_byte;
            pending_d = 1'b1;
            if (pending_q && !tx_start) begin
                overrun_d = 1'b1;
            end
        end
    end

    // State update; reset drops any partial packet and any unsent response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_SYNC;
            id_q      <= 8'h00;
            hi_q      <= 8'h00;
            lo_q      <= 8'h00;
            idle_q    <= '0;
            err_q     <= 8'h00;
            for (int i = 0; i < 6; i++) begin
                regs_q[i] <= 15'h0000;
            end
            strobe_q  <= 6'b000000;
            tx_data_q <= 8'h00;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            idle_q    <= idle_d;
            err_q     <= err_d;
            regs_q    <= regs_d;
            strobe_q  <= strobe_d;
            tx_data_q <= tx_data_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign DSKY_VERB_data = regs_q[0];
    assign DSKY_NOUN_data = regs_q[1];
    assign AXI_G_data     = regs_q[2];
    assign AXI_RA_data    = regs_q[3];
    assign AXI_RB_data    = regs_q[4];
    assign AXI_ATX_data   = regs_q[5];
    assign update_strobe  = strobe_q;
    assign err_count      = err_q;
    assign tx_data        = tx_data_q;
    assign resp_overrun   = overrun_q;

endmodule
